// File: rtl/audio_frame_aligner.sv
// rtl/audio_frame_aligner.sv - per-channel elastic FIFOs merged into aligned frames, lane 0 through a programmable delay line
// Optional macro AUDIO_ALIGN_TIMEOUT_EN adds the lagging-channel timeout and partial-frame emission.
module audio_frame_aligner #(
   parameter int NUM_CH     = 2,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int DELAY_MAX  = 64,
   parameter int TIMEOUT    = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH*DATA_W-1:0]   ch_data,
   input  logic [NUM_CH-1:0]          ch_valid,
   input  logic [$clog2(DELAY_MAX)-1:0] ref_delay,
   output logic [NUM_CH*DATA_W-1:0]   frame_data,
   output logic [NUM_CH-1:0]          frame_partial,
   output logic                       frame_valid,
   input  logic                       frame_ready,
   output logic [NUM_CH-1:0]          ovf_flags,
   output logic [15:0]                drop_cnt
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int DAW = $clog2(DELAY_MAX);
   localparam logic [AW:0]    OCC_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [DAW-1:0] FILL_MAX = DAW'(DELAY_MAX - 1);

   if (NUM_CH < 2 || NUM_CH > 8 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       DELAY_MAX < 2 || (DELAY_MAX & (DELAY_MAX - 1)) != 0 || TIMEOUT < 2) begin : g_bad_cfg
      $error("audio_frame_aligner: illegal parameter set");
   end

`ifdef AUDIO_ALIGN_TIMEOUT_EN
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT_FULL, S_EMIT_PART} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT_FULL} state_t;
`endif
   state_t state, state_nxt;

   logic [DATA_W-1:0] fifo_mem [NUM_CH][FIFO_DEPTH];
   logic [AW-1:0]     wr_idx   [NUM_CH];
   logic [AW-1:0]     rd_idx   [NUM_CH];
   logic [AW:0]       occ      [NUM_CH];
   logic [AW:0]       occ_nxt  [NUM_CH];
   logic [DATA_W-1:0] lane     [NUM_CH];
   logic [NUM_CH-1:0] not_empty, not_empty_nxt, push_ok, drop, pop;
   logic              emit, out_free;
   logic [NUM_CH*DATA_W-1:0] frame_nxt;

   logic [DATA_W-1:0] dly_mem [DELAY_MAX];
   logic [DAW-1:0]    dly_wr, dly_fill;
   logic [DATA_W-1:0] ref_out;
   logic [16:0]       drop_sum;

   assign out_free = !frame_valid || frame_ready;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         not_empty[i] = (occ[i] != '0);
         lane[i]      = not_empty[i] ? fifo_mem[i][rd_idx[i]] : '0;
      end
   end

   // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         push_ok[i] = ch_valid[i] && ((occ[i] != OCC_FULL) || pop[i]);
         drop[i]    = ch_valid[i] && (occ[i] == OCC_FULL) && !pop[i];
         occ_nxt[i] = occ[i];
         if (push_ok[i] && !pop[i])
            occ_nxt[i] = occ[i] + (AW+1)'(1);
         else if (!push_ok[i] && pop[i])
            occ_nxt[i] = occ[i] - (AW+1)'(1);
         not_empty_nxt[i] = (occ_nxt[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_idx[i] <= '0;
            rd_idx[i] <= '0;
            occ[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push_ok[i])
               wr_idx[i] <= wr_idx[i] + AW'(1);
            if (pop[i])
               rd_idx[i] <= rd_idx[i] + AW'(1);
            occ[i] <= occ_nxt[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rst && push_ok[i])
            fifo_mem[i][wr_idx[i]] <= ch_data[i*DATA_W +: DATA_W];
      end
   end

`ifdef AUDIO_ALIGN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;

   assign tmo_hit = (tmo_cnt == TMO_LAST);

   // Held at zero outside WAIT, so every entry into WAIT starts a fresh count.
   always_ff @(posedge clk) begin
      if (rst || state != S_WAIT)
         tmo_cnt <= '0;
      else if (!tmo_hit)
         tmo_cnt <= tmo_cnt + TW'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (|not_empty)
               state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (&not_empty && out_free)
               state_nxt = S_EMIT_FULL;
`ifdef AUDIO_ALIGN_TIMEOUT_EN
            else if (tmo_hit && out_free)
               state_nxt = S_EMIT_PART;
`endif
         end
         default: state_nxt = (|not_empty_nxt) ? S_WAIT : S_IDLE;
      endcase
   end

   always_comb begin
      emit = 1'b0;
      case (state)
         S_EMIT_FULL: emit = 1'b1;
`ifdef AUDIO_ALIGN_TIMEOUT_EN
         S_EMIT_PART: emit = 1'b1;
`endif
         default:     emit = 1'b0;
      endcase
      pop = emit ? not_empty : '0;
   end

   // Zero history is masked by the fill count rather than by clearing the RAM.
   always_comb begin
      ref_out = '0;
      if (ref_delay == '0)
         ref_out = lane[0];
      else if (dly_fill >= ref_delay)
         ref_out = dly_mem[dly_wr - ref_delay];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dly_wr   <= '0;
         dly_fill <= '0;
      end else if (emit) begin
         dly_wr <= dly_wr + DAW'(1);
         if (dly_fill != FILL_MAX)
            dly_fill <= dly_fill + DAW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && emit)
         dly_mem[dly_wr] <= lane[0];
   end

   always_comb begin
      frame_nxt = '0;
      for (int i = 0; i < NUM_CH; i++)
         frame_nxt[i*DATA_W +: DATA_W] = (i == 0) ? ref_out : lane[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_valid <= 1'b0;
         frame_data  <= '0;
      end else if (emit) begin
         frame_valid <= 1'b1;
         frame_data  <= frame_nxt;
      end else if (frame_ready) begin
         frame_valid <= 1'b0;
      end
   end

`ifdef AUDIO_ALIGN_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst)
         frame_partial <= '0;
      else if (emit)
         frame_partial <= ~not_empty;
   end
`else
   assign frame_partial = '0;
`endif

   always_comb begin
      drop_sum = {1'b0, drop_cnt};
      for (int i = 0; i < NUM_CH; i++)
         drop_sum = drop_sum + 17'(drop[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_flags <= '0;
         drop_cnt  <= '0;
      end else begin
         ovf_flags <= ovf_flags | drop;
         drop_cnt  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end
endmodule

// File: tb/tb_audio_frame_aligner.sv
// tb/tb_audio_frame_aligner.sv - scoreboard bench for audio_frame_aligner
module tb_audio_frame_aligner;
   localparam int NUM_CH     = 2;
   localparam int DATA_W     = 16;
   localparam int FIFO_DEPTH = 8;
   localparam int DELAY_MAX  = 64;
   localparam int TIMEOUT    = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ch_data;
   logic [1:0]  ch_valid;
   logic [5:0]  ref_delay;
   logic [31:0] frame_data;
   logic [1:0]  frame_partial;
   logic        frame_valid;
   logic        frame_ready;
   logic [1:0]  ovf_flags;
   logic [15:0] drop_cnt;

   always #5 clk = ~clk;

   audio_frame_aligner #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
      .DELAY_MAX(DELAY_MAX), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
      .ref_delay(ref_delay), .frame_data(frame_data), .frame_partial(frame_partial),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .ovf_flags(ovf_flags), .drop_cnt(drop_cnt)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  partial;
   } frame_t;

   frame_t      exp_q[$];
   logic [15:0] cq0[$];
   logic [15:0] cq1[$];
   logic [15:0] hist[$];
   int          nframes;
   int          exp_drops;
   logic [1:0]  exp_ovf;
   int          errors = 0;
   int          checks = 0;
   frame_t      mon_e;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_frame(input logic [15:0] v0, input logic [15:0] v1, input logic [1:0] part);
      logic [15:0] l0;
      int d;
      d = int'(ref_delay);
      if (d == 0)
         l0 = v0;
      else if (nframes >= d)
         l0 = hist[nframes - d];
      else
         l0 = 16'h0000;
      hist.push_back(v0);
      nframes++;
      exp_q.push_back({{v1, l0}, part});
   endtask

   task automatic model_reset();
      exp_q.delete();
      cq0.delete();
      cq1.delete();
      hist.delete();
      nframes   = 0;
      exp_drops = 0;
      exp_ovf   = 2'b00;
   endtask

   task automatic push(input logic [1:0] m, input logic [15:0] d0, input logic [15:0] d1);
      ch_valid = m;
      ch_data  = {d1, d0};
      if (m[0]) begin
         if (cq0.size() >= FIFO_DEPTH) begin exp_drops++; exp_ovf[0] = 1'b1; end
         else cq0.push_back(d0);
      end
      if (m[1]) begin
         if (cq1.size() >= FIFO_DEPTH) begin exp_drops++; exp_ovf[1] = 1'b1; end
         else cq1.push_back(d1);
      end
      while (cq0.size() > 0 && cq1.size() > 0)
         model_frame(cq0.pop_front(), cq1.pop_front(), 2'b00);
      @(posedge clk); #1;
      ch_valid = 2'b00;
   endtask

   task automatic wait_valid(output int n, input int max);
      n = 0;
      while (n < max) begin
         @(negedge clk);
         if (frame_valid) break;
         n++;
      end
      if (n >= max) check("wait_valid_timeout", 1, 0);
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || frame_valid) && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"},   frame_valid,   0);
      check({tag, "_data"},    frame_data,    0);
      check({tag, "_partial"}, frame_partial, 0);
      check({tag, "_ovf"},     ovf_flags,     0);
      check({tag, "_drop"},    drop_cnt,      0);
   endtask

   always @(negedge clk) begin
      if (!rst && frame_valid && frame_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("frame_data", frame_data, mon_e.data);
            check("frame_partial", frame_partial, mon_e.partial);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; ch_valid = 2'b00; ch_data = '0; ref_delay = '0; frame_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("reset");
      @(posedge clk); #1;

      // Delay line: ramp with ref_delay 3, then shorten to 1.
      ref_delay = 6'd3;
      for (int k = 1; k <= 5; k++) begin
         push(2'b11, 16'(k), 16'(99 + k));
         repeat (6) @(posedge clk); #1;
      end
      drain(50);
      ref_delay = 6'd1;
      push(2'b11, 16'd6, 16'd105);
      drain(50);

      // Basic alignment and latency from the last-arriving strobe.
      ref_delay = 6'd0;
      push(2'b01, 16'h1234, 16'h0000);
      repeat (3) @(posedge clk); #1;
      push(2'b10, 16'h0000, 16'hABCD);
      wait_valid(n, 20);
      check("latency", n + 1, 3);
      drain(20);

      // Backpressure: output must hold while stalled, then frames drain in order.
      frame_ready = 1'b0;
      for (int k = 0; k < 3; k++)
         push(2'b11, 16'h0A00 + 16'(k), 16'h0B00 + 16'(k));
      wait_valid(n, 20);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("bp_hold_valid", frame_valid, 1);
         if (exp_q.size() > 0) check("bp_hold_data", frame_data, exp_q[0].data);
      end
      @(posedge clk); #1;
      frame_ready = 1'b1;
      drain(40);

      // Overflow on ch1 with ch0 silent, then release with ch0.
      for (int k = 0; k < 10; k++)
         push(2'b10, 16'h0000, 16'(k));
      repeat (2) @(posedge clk); #1;
      check("ovf_flags", ovf_flags, exp_ovf);
      check("drop_cnt", drop_cnt, 16'(exp_drops));
      for (int k = 0; k < 8; k++)
         push(2'b01, 16'h0C00 + 16'(k), 16'h0000);
      drain(80);
      check("ovf_sticky", ovf_flags, exp_ovf);

`ifdef AUDIO_ALIGN_TIMEOUT_EN
      // Lone ch0 sample must come out as a partial frame after the timeout.
      push(2'b01, 16'h0101, 16'h0000);
      model_frame(cq0.pop_front(), 16'h0000, 2'b10);
      wait_valid(n, TIMEOUT + 100);
      check("timeout_window", (n >= TIMEOUT && n <= TIMEOUT + 4), 1);
      drain(20);
`endif

      // Reset with samples buffered and a frame pending.
      ref_delay   = 6'd2;
      frame_ready = 1'b0;
      push(2'b11, 16'h0D01, 16'h0E01);
      push(2'b11, 16'h0D02, 16'h0E02);
      push(2'b11, 16'h0D03, 16'h0E03);
      repeat (4) @(posedge clk); #1;
      check("pre_rst_valid", frame_valid, 1);
      rst = 1'b1;
      ch_valid = 2'b01;
      ch_data  = 32'h0000_7777;
      @(posedge clk); #1;
      rst = 1'b0;
      ch_valid = 2'b00;
      model_reset();
      @(negedge clk);
      check_reset_state("mid_reset");
      @(posedge clk); #1;
      frame_ready = 1'b1;
      push(2'b11, 16'h0F01, 16'h0F11);
      push(2'b11, 16'h0F02, 16'h0F12);
      push(2'b11, 16'h0F03, 16'h0F13);
      drain(40);

      check("final_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
